// File: rtl/disp_pkg.sv
// Shared types and constants for the display scan controller.
// No logic, no latency, no flow control.
package disp_pkg;

    localparam int         NUM_DIGITS = 4;
    localparam logic [3:0] ANODE_OFF  = 4'b1111;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } state_t;

    typedef logic [1:0] digit_t;

    // Nibble of a 16-bit display value for one digit; digit 0 is [3:0].
    function automatic logic [3:0] nibble(input logic [15:0] value, input digit_t d);
        return value[{d, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Core-side value/load inputs and display-side anode/nibble/dp outputs.
// Plain wires; the controller registers everything it drives.
interface seg_scan_ctrl_if;

    logic                                enable;
    logic [15:0]                         data_in;
    logic [disp_pkg::NUM_DIGITS-1:0]     dp_in;
    logic                                load;
    logic [disp_pkg::NUM_DIGITS-1:0]     anode;
    logic [3:0]                          hex_out;
    logic                                dp_out;
    logic                                frame_done;

    modport master (
        output enable, data_in, dp_in, load,
        input  anode, hex_out, dp_out, frame_done
    );

    modport slave (
        input  enable, data_in, dp_in, load,
        output anode, hex_out, dp_out, frame_done
    );

endinterface

// File: rtl/seg_phase_counter.sv
// Phase counter: counts 0..limit, pulses tc on the last count, then wraps.
// Latency: tc is combinational from the count; no backpressure.
module seg_phase_counter #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == limit);

    always_ff @(posedge clk) begin
        if (reset || clr || tc) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// 4-digit 7-seg scan controller with dead-time blanking; optional LEADING_ZERO_BLANK_EN.
// Latency: a load shows from the next frame boundary; outputs are registered-state decodes.
// Backpressure: none; load is always accepted, the last load before a boundary wins.
module seg_scan_ctrl
    import disp_pkg::*;
#(
    parameter int ON_CYCLES   = 50000,
    parameter int DEAD_CYCLES = 500,
    parameter int CNT_W       = 20
) (
    input  logic            clk,
    input  logic            reset,
    seg_scan_ctrl_if.slave  bus
);

    state_t      state, state_nxt;
    digit_t      digit, digit_nxt;
    logic [15:0] shadow, shadow_nxt, pending;
    logic [3:0]  dp_shadow, dp_shadow_nxt, dp_pend;
    logic        pend_flag;
    logic        en_q;
    logic [3:0]  hex_q, hex_nxt;
    logic        frame_q;
    logic        tc;
    logic        boundary, restart, apply, lit;
    logic [3:0]  anode_c;
    logic        dp_c;
    logic [CNT_W-1:0] limit;

    assign limit = (state == BLANK) ? CNT_W'(DEAD_CYCLES - 1) : CNT_W'(ON_CYCLES - 1);

    seg_phase_counter #(.CNT_W(CNT_W)) u_phase (
        .clk   (clk),
        .reset (reset),
        .clr   (~bus.enable),
        .limit (limit),
        .tc    (tc)
    );

    assign boundary = bus.enable && (state == ON) && tc && (digit == 2'd3);
    assign restart  = bus.enable && !en_q;
    assign apply    = boundary || restart;

`ifdef LEADING_ZERO_BLANK_EN
    assign lit = (digit == 2'd0) || dp_shadow[digit] || ((shadow >> {digit, 2'b00}) != 16'h0);
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        state_nxt     = state;
        digit_nxt     = digit;
        shadow_nxt    = shadow;
        dp_shadow_nxt = dp_shadow;
        hex_nxt       = hex_q;
        anode_c       = ANODE_OFF;
        dp_c          = 1'b1;

        // A load on the apply edge bypasses pending so it is not lost.
        if (apply && bus.load) begin
            shadow_nxt    = bus.data_in;
            dp_shadow_nxt = bus.dp_in;
        end else if (apply && pend_flag) begin
            shadow_nxt    = pending;
            dp_shadow_nxt = dp_pend;
        end

        if (!bus.enable) begin
            state_nxt = BLANK;
            digit_nxt = '0;
        end else if (tc) begin
            if (state == BLANK) begin
                state_nxt = ON;
            end else begin
                state_nxt = BLANK;
                digit_nxt = digit_t'(digit + 2'd1);
            end
        end

        if (!bus.enable || restart) begin
            hex_nxt = nibble(shadow_nxt, 2'd0);
        end else if (state == ON && tc) begin
            hex_nxt = nibble(shadow_nxt, digit_t'(digit + 2'd1));
        end

        if (state == ON && lit) begin
            anode_c = ~(4'b0001 << digit);
            dp_c    = ~dp_shadow[digit];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= BLANK;
            digit     <= '0;
            shadow    <= '0;
            dp_shadow <= '0;
            pending   <= '0;
            dp_pend   <= '0;
            pend_flag <= 1'b0;
            en_q      <= 1'b0;
            hex_q     <= '0;
            frame_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            digit     <= digit_nxt;
            shadow    <= shadow_nxt;
            dp_shadow <= dp_shadow_nxt;
            en_q      <= bus.enable;
            hex_q     <= hex_nxt;
            frame_q   <= boundary;
            if (bus.load) begin
                pending <= bus.data_in;
                dp_pend <= bus.dp_in;
            end
            if (apply) begin
                pend_flag <= 1'b0;
            end else if (bus.load) begin
                pend_flag <= 1'b1;
            end
        end
    end

    assign bus.anode      = anode_c;
    assign bus.dp_out     = dp_c;
    assign bus.hex_out    = hex_q;
    assign bus.frame_done = frame_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with ON_CYCLES=4, DEAD_CYCLES=2 (24-cycle frames).
// Expected per-cycle outputs are queued with cycle stamps; a negedge monitor pops and compares.
module tb_seg_scan_ctrl;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    logic done;

    seg_scan_ctrl_if bus();

    seg_scan_ctrl #(
        .ON_CYCLES   (4),
        .DEAD_CYCLES (2),
        .CNT_W       (20)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] anode;
        logic [3:0] hex;
        logic       hchk;
        logic       dp;
        logic       fd;
    } exp_t;

    exp_t q[$];

    task automatic push(input int c, input logic [3:0] a, input logic [3:0] h,
                        input logic hc, input logic d, input logic f);
        exp_t e;
        e.cyc = c; e.anode = a; e.hex = h; e.hchk = hc; e.dp = d; e.fd = f;
        q.push_back(e);
    endtask

    // Frame starting at cycle f: per digit 2 blank cycles then 4 lit cycles.
    task automatic push_frame(input int f, input logic [15:0] d, input logic [3:0] dpv,
                              input logic fd0, input logic hchk0, input int n);
        for (int i = 0; i < n; i++) begin
            int         dg;
            logic       on, lt;
            logic [3:0] one, a;
            logic [15:0] dd;
            logic       dpo;
            dg  = i / 6;
            on  = ((i % 6) >= 2);
            dd  = d >> (4 * dg);
            lt  = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            lt  = (dg == 0) || dpv[dg] || (dd != 16'h0);
`endif
            one = 4'b0001;
            a   = (on && lt) ? ~(one << dg) : 4'b1111;
            dpo = (on && lt) ? ~dpv[dg] : 1'b1;
            push(f + i, a, dd[3:0], (i == 0) ? hchk0 : 1'b1, dpo, (i == 0) ? fd0 : 1'b0);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Load is sampled on edge c.
    task automatic do_load(input int c, input logic [15:0] v, input logic [3:0] p);
        wait_until(c - 1);
        bus.load    = 1'b1;
        bus.data_in = v;
        bus.dp_in   = p;
        wait_until(c);
        bus.load    = 1'b0;
    endtask

    initial begin
        done        = 1'b0;
        reset       = 1'b1;
        bus.enable  = 1'b0;
        bus.load    = 1'b0;
        bus.data_in = 16'h0;
        bus.dp_in   = 4'h0;

        wait_until(2);
        reset      = 1'b0;
        bus.enable = 1'b1;
        push_frame(2,  16'h0000, 4'b0000, 1'b0, 1'b1, 24);
        push_frame(26, 16'h0000, 4'b0000, 1'b1, 1'b1, 24);
        push_frame(50, 16'h0000, 4'b0000, 1'b1, 1'b1, 24);
        push_frame(74, 16'h1A3F, 4'b0100, 1'b1, 1'b1, 24);
        do_load(60, 16'h1A3F, 4'b0100);

        push_frame(98,  16'h1A3F, 4'b0100, 1'b1, 1'b1, 24);
        push_frame(122, 16'h2222, 4'b0000, 1'b1, 1'b1, 24);
        do_load(100, 16'h1111, 4'b0000);
        do_load(110, 16'h2222, 4'b0000);

        // Load exactly on the boundary edge of the frame starting at 146.
        push_frame(146, 16'hBEEF, 4'b0000, 1'b1, 1'b1, 24);
        push_frame(170, 16'hBEEF, 4'b0000, 1'b1, 1'b1, 15);
        do_load(146, 16'hBEEF, 4'b0000);

        // Drop enable while digit 2 is lit; hex is unspecified while dark.
        for (int c = 185; c <= 193; c++) push(c, 4'b1111, 4'h0, 1'b0, 1'b1, 1'b0);
        wait_until(184);
        bus.enable = 1'b0;
        push_frame(194, 16'h4567, 4'b0001, 1'b0, 1'b0, 24);
        push_frame(218, 16'h4567, 4'b0001, 1'b1, 1'b1, 16);
        do_load(190, 16'h4567, 4'b0001);
        wait_until(194);
        bus.enable = 1'b1;

        // Reset during digit 2 ON discards a pending value.
        push_frame(234, 16'h0000, 4'b0000, 1'b0, 1'b1, 24);
        push_frame(258, 16'h0000, 4'b0000, 1'b1, 1'b1, 24);
        do_load(230, 16'h9999, 4'b1111);
        wait_until(233);
        reset = 1'b1;
        wait_until(234);
        reset = 1'b0;

        wait_until(258);
        push_frame(282, 16'h0005, 4'b0000, 1'b1, 1'b1, 24);
        do_load(270, 16'h0005, 4'b0000);
        push_frame(306, 16'h0000, 4'b0000, 1'b1, 1'b1, 24);
        do_load(294, 16'h0000, 4'b0000);

        wait_until(330);
        done = 1'b1;
    end

    initial begin
        checks = 0;
        errors = 0;
    end

    always @(negedge clk) begin
        if (cyc >= 2) begin
            checks++;
            if ($countones(~bus.anode) > 1) begin
                errors++;
                $display("FAIL one_hot cyc=%0d anode=%b (at most one low bit required)", cyc, bus.anode);
            end
        end
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc) begin
                checks++;
                errors++;
                $display("FAIL skipped cyc=%0d expected entry for cyc=%0d", cyc, e.cyc);
            end else begin
                checks++;
                if (bus.anode !== e.anode) begin
                    errors++;
                    $display("FAIL anode cyc=%0d got=%b exp=%b", cyc, bus.anode, e.anode);
                end
                checks++;
                if (bus.dp_out !== e.dp) begin
                    errors++;
                    $display("FAIL dp_out cyc=%0d got=%b exp=%b", cyc, bus.dp_out, e.dp);
                end
                checks++;
                if (bus.frame_done !== e.fd) begin
                    errors++;
                    $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, bus.frame_done, e.fd);
                end
                if (e.hchk) begin
                    checks++;
                    if (bus.hex_out !== e.hex) begin
                        errors++;
                        $display("FAIL hex_out cyc=%0d got=%h exp=%h", cyc, bus.hex_out, e.hex);
                    end
                end
            end
        end
        if (done) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL leftover got=%0d entries exp=0", q.size());
            end
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 4-digit common-anode 7-segment display. Holds a 16-bit display value, walks one digit at a time with a dead-time blanking gap between digits, and drives the active-low anodes, the current nibble and the decimal point. Sits in the DisplayController between core logic (value/load) and the hex_to_7seg decoder, which is driven from hex_out. Display updates apply only at frame boundaries, so a value is never shown partly old and partly new.

Parameters:
ON_CYCLES, 50000, clocks each digit's anode is asserted; legal range >= 1
DEAD_CYCLES, 500, clocks all anodes are off before each digit; legal range >= 1
CNT_W, 20, phase counter width; must hold max(ON_CYCLES, DEAD_CYCLES)-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
enable  in  1  1 = scanning, 0 = display dark
data_in  in  16  value to display; [3:0] goes to digit 0 (rightmost)
dp_in  in  4  decimal point per digit, 1 = lit
load  in  1  1-cycle strobe capturing data_in/dp_in
anode  out  4  active-low anode enables; anode[i] drives digit i
hex_out  out  4  nibble for the current digit, to hex_to_7seg
dp_out  out  1  active-low decimal point
frame_done  out  1  1-cycle pulse at each frame boundary

Behaviour:
- Single clock domain. reset is synchronous and active-high; all state is updated on the rising edge of clk.
- Reset values: anode=4'b1111, hex_out=0, dp_out=1, frame_done=0, state=BLANK, digit=0, cnt=0, shadow data/dp=0, pending data/dp=0, pend_flag=0.
- FSM states:
  - BLANK: anode=1111 and dp_out=1. cnt runs 0..DEAD_CYCLES-1, then the FSM goes to ON with cnt=0.
  - ON: anode[digit]=0, all other anodes are 1, and dp_out=~dp_shadow[digit]. cnt runs 0..ON_CYCLES-1, then the FSM goes to BLANK with digit=digit+1 (mod 4) and cnt=0.
- hex_out is registered. It loads shadow[4*digit+3 -: 4] on entry to BLANK for the new digit, so it is stable DEAD_CYCLES before the anode asserts.
- Frame: 4*(DEAD_CYCLES+ON_CYCLES) cycles. The boundary is the ON->BLANK transition from digit 3 to digit 0. frame_done is high in the cycle after that edge.
- load: captures data_in/dp_in into the pending registers and sets pend_flag.
- At the boundary with pend_flag=1: shadow<=pending, pend_flag<=0, and the new digit-0 hex_out comes from the new shadow.
- Repeated loads before a boundary: the last one wins.
- load in the same cycle as the boundary: data_in/dp_in go straight to shadow and pend_flag ends 0.
- enable=0: on the next edge the FSM forces BLANK, digit=0, cnt=0, anode=1111, dp_out=1, and frame_done stays 0. Loads are still accepted.
- enable rising: scanning restarts from BLANK digit 0. Any pending value is applied immediately on that restart edge.
- reset mid-frame: returns to reset values on the next edge; the pending value is lost.
- Invariant: at most one anode bit is low in any cycle.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN.
- Defined: during ON, a digit stays unlit (anode bit held 1, dp_out=1) when its nibble is 0, every higher digit's nibble is 0, its dp_shadow bit is 0, and it is not digit 0. Timing is unchanged.
- Not defined: every digit is lit during its ON phase.

Decomposition:
- Shared package disp_pkg:
  - NUM_DIGITS=4
  - ANODE_OFF=4'b1111
  - state encoding (BLANK=1'b0, ON=1'b1)
  - digit index type (2 bits)
- Natural sub-module: seg_phase_counter, a loadable counter with terminal-count output, instantiated once and reloaded with DEAD_CYCLES-1 or ON_CYCLES-1.
- hex_to_7seg is instantiated by the parent, not inside this block.

Test Plan:
All cases use ON_CYCLES=4, DEAD_CYCLES=2 unless noted.
- Reset, then enable=1, no load -> anode sequence per frame: 1111 x2, 1110 x4, 1111 x2, 1101 x4, 1111 x2, 1011 x4, 1111 x2, 0111 x4; hex_out=0; frame_done pulses every 24 cycles.
- load data_in=16'h1A3F, dp_in=4'b0100 mid-frame -> the current frame is unchanged. Next frame: hex_out F, 3, A, 1 for digits 0..3; dp_out=0 only while anode=1011.
- Two loads (16'h1111, then 16'h2222) in one frame -> the next frame shows 2222 only. A load of 16'hBEEF exactly on the boundary cycle -> digit 0 shows F in that same frame.
- enable dropped while anode=1011 -> anode=1111 on the next edge and held. Re-enable -> restarts at 1111 x2 then 1110.
- reset asserted during ON of digit 2 -> all outputs at reset values on the next edge. Check every cycle that no more than one anode bit is 0.
- LEADING_ZERO_BLANK_EN defined, data_in=16'h0005, dp_in=0 -> only digit 0 ever lights (anode 1110). data_in=16'h0000 -> digit 0 lights showing 0.
